// File: rtl/csa_reduction_pipe.sv
// Pipelined 3:2 carry-save reduction of PARM_NUM_PP operands to a sum/carry pair.
// Optional macro CSA_REDUCTION_OVF_EN adds ovf_o, the OR of all discarded carry MSBs.
module csa_reduction_pipe #(
    parameter int PARM_WIDTH         = 49,
    parameter int PARM_NUM_PP        = 13,
    parameter int PARM_LVL_PER_STAGE = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [PARM_NUM_PP*PARM_WIDTH-1:0] pp_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic [PARM_WIDTH-1:0]             sum_o,
    output logic [PARM_WIDTH-1:0]             carry_o,
    output logic                              valid_o,
    input  logic                              ready_i
`ifdef CSA_REDUCTION_OVF_EN
    ,
    output logic                              ovf_o
`endif
);

    localparam int W = PARM_WIDTH;

    function automatic int ops_at(int lvl);
        int n;
        n = PARM_NUM_PP;
        for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    function automatic int num_levels();
        int n;
        int l;
        n = PARM_NUM_PP;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = num_levels();
    localparam int STAGES = (LEVELS + PARM_LVL_PER_STAGE - 1) / PARM_LVL_PER_STAGE;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    // Backpressure ripples from the output stage toward the input.
    always_comb begin
        vin = '0;
        adv = '0;
        ld  = '0;
        vin[0] = valid_i;
        for (int s = 1; s < STAGES; s++) vin[s] = vld[s-1];
        adv[STAGES-1] = vld[STAGES-1] & ready_i;
        ld[STAGES-1]  = ~vld[STAGES-1] | adv[STAGES-1];
        for (int s = STAGES - 2; s >= 0; s--) begin
            adv[s] = vld[s] & ld[s+1];
            ld[s]  = ~vld[s] | adv[s];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ld[s]) vld[s] <= vin[s];
            end
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NI = ops_at(l);
        localparam int NO = ops_at(l + 1);
        localparam int NG = NI / 3;
        localparam int NR = NI % 3;
        localparam bit REG = ((l + 1) % PARM_LVL_PER_STAGE == 0) || (l == LEVELS - 1);

        logic [W-1:0] din  [NI];
        logic [W-1:0] dout [NO];
        logic [W-1:0] q    [NO];
`ifdef CSA_REDUCTION_OVF_EN
        logic          oin;
        logic          oout;
        logic          oq;
        logic [NG-1:0] cbits;
`endif

        if (l == 0) begin : g_src
            for (genvar k = 0; k < NI; k++) begin : g_op
                assign din[k] = pp_i[k*W +: W];
            end
`ifdef CSA_REDUCTION_OVF_EN
            assign oin = 1'b0;
`endif
        end else begin : g_chain
            for (genvar k = 0; k < NI; k++) begin : g_op
                assign din[k] = g_lvl[l-1].q[k];
            end
`ifdef CSA_REDUCTION_OVF_EN
            assign oin = g_lvl[l-1].oq;
`endif
        end

        for (genvar g = 0; g < NG; g++) begin : g_csa
            assign dout[2*g]   = din[3*g] ^ din[3*g+1] ^ din[3*g+2];
            assign dout[2*g+1] = ((din[3*g] & din[3*g+1]) | (din[3*g] & din[3*g+2])
                                 | (din[3*g+1] & din[3*g+2])) << 1;
`ifdef CSA_REDUCTION_OVF_EN
            assign cbits[g] = (din[3*g][W-1] & din[3*g+1][W-1]) | (din[3*g][W-1] & din[3*g+2][W-1])
                            | (din[3*g+1][W-1] & din[3*g+2][W-1]);
`endif
        end

        for (genvar r = 0; r < NR; r++) begin : g_pass
            assign dout[2*NG+r] = din[3*NG+r];
        end

`ifdef CSA_REDUCTION_OVF_EN
        assign oout = oin | (|cbits);
`endif

        if (REG) begin : g_reg
            // Data only loads with a valid operand set so idle outputs stay quiet.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int k = 0; k < NO; k++) q[k] <= '0;
`ifdef CSA_REDUCTION_OVF_EN
                    oq <= 1'b0;
`endif
                end else if (ld[l/PARM_LVL_PER_STAGE] && vin[l/PARM_LVL_PER_STAGE]) begin
                    for (int k = 0; k < NO; k++) q[k] <= dout[k];
`ifdef CSA_REDUCTION_OVF_EN
                    oq <= oout;
`endif
                end
            end
        end else begin : g_comb
            for (genvar k = 0; k < NO; k++) begin : g_op
                assign q[k] = dout[k];
            end
`ifdef CSA_REDUCTION_OVF_EN
            assign oq = oout;
`endif
        end
    end

    assign ready_o = ld[0];
    assign valid_o = vld[STAGES-1];
    assign sum_o   = g_lvl[LEVELS-1].q[0];
    assign carry_o = g_lvl[LEVELS-1].q[1];
`ifdef CSA_REDUCTION_OVF_EN
    assign ovf_o   = g_lvl[LEVELS-1].oq;
`endif

endmodule
